// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM encodings, RV64
// load/store width codes and access-legality checks.
package lsu_pkg;

  typedef logic [2:0] lsu_state_e;

  localparam lsu_state_e ST_IDLE   = 3'd0;
  localparam lsu_state_e ST_ACCESS = 3'd1;
  localparam lsu_state_e ST_READ   = 3'd2;
  localparam lsu_state_e ST_WRITE  = 3'd3;
  localparam lsu_state_e ST_RESP   = 3'd4;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  // funct3[1:0] encodes log2 of the access size for every legal code.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'd1:    mis = addr_lo[0] != 1'b0;
      2'd2:    mis = addr_lo[1:0] != 2'b00;
      2'd3:    mis = addr_lo != 3'b000;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_unsupported(input logic [2:0] f3, input logic store);
    return (f3 == 3'd7) || (store && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment datapath: extracts and extends load data from a memory
// word and merges sub-doubleword store data into an old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  output logic [63:0] load_data,
  output logic [63:0] merged_data
);

  logic [63:0] shifted_rdata;
  logic [63:0] shifted_wdata;
  logic [7:0]  base_mask;
  logic [7:0]  byte_mask;

  assign shifted_rdata = word >> {lane, 3'b000};
  assign shifted_wdata = wdata << {lane, 3'b000};
  assign byte_mask     = base_mask << lane;

  always_comb begin
    load_data = shifted_rdata;
    case (funct3)
      F3_B:    load_data = {{56{shifted_rdata[7]}}, shifted_rdata[7:0]};
      F3_H:    load_data = {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
      F3_W:    load_data = {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
      F3_BU:   load_data = {56'd0, shifted_rdata[7:0]};
      F3_HU:   load_data = {48'd0, shifted_rdata[15:0]};
      F3_WU:   load_data = {32'd0, shifted_rdata[31:0]};
      default: load_data = shifted_rdata;
    endcase
  end

  always_comb begin
    base_mask = 8'h01;
    case (funct3[1:0])
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      2'd3:    base_mask = 8'hFF;
      default: base_mask = 8'h01;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged_data[8*gi +: 8] = byte_mask[gi] ? shifted_wdata[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, read-modify-write for
// sub-doubleword stores, registered response held until consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit ERR_ON_X = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_we
);

  lsu_state_e      state_reg, state_next;
  logic            store_reg;
  logic [2:0]      funct3_reg;
  logic [2:0]      lane_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] resp_rdata_reg;
  logic            resp_err_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic [XLEN-1:0] mem_wdata_reg;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_data;
  logic            req_bad;
  logic            accept;

  assign req_bad = is_unsupported(req_funct3, req_store) || is_misaligned(req_funct3, req_addr[2:0]);
  assign accept  = req_valid && (state_reg == ST_IDLE);

  assign req_ready  = state_reg == ST_IDLE;
  assign resp_valid = state_reg == ST_RESP;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  // Gated by rst_n so a reset edge never lands a partial store.
  assign mem_we     = rst_n && ((state_reg == ST_WRITE) || (state_reg == ST_ACCESS && store_reg));

  lsu_align u_align (
    .word        (mem_rdata),
    .wdata       (wdata_reg),
    .lane        (lane_reg),
    .funct3      (funct3_reg),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad)
            state_next = ST_RESP;
          else if (!req_store || req_funct3 == F3_D)
            state_next = ST_ACCESS;
          else
            state_next = ST_READ;
        end
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_READ:   state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_RESP;
      ST_RESP:   state_next = resp_ready ? ST_IDLE : ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      store_reg      <= 1'b0;
      funct3_reg     <= 3'd0;
      lane_reg       <= 3'd0;
      wdata_reg      <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            store_reg      <= req_store;
            funct3_reg     <= req_funct3;
            lane_reg       <= req_addr[2:0];
            wdata_reg      <= req_wdata;
            resp_rdata_reg <= '0;
            resp_err_reg   <= req_bad && ERR_ON_X;
            // Rejected requests leave the memory port untouched.
            if (!req_bad) begin
              mem_addr_reg <= {req_addr[XLEN-1:3], 3'b000};
              if (req_store && req_funct3 == F3_D)
                mem_wdata_reg <= req_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (!store_reg)
            resp_rdata_reg <= load_data;
        end
        ST_READ: mem_wdata_reg <= merged_data;
        ST_RESP: begin
          if (resp_ready) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_we;

  logic [63:0] mem [0:31];
  logic [7:0]  ref_bytes [0:255];
  logic        preload = 1'b1;
  int          we_count = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we)
  );

  function automatic logic [63:0] bytes_to_word(input int idx);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_bytes[idx*8 + b];
    return w;
  endfunction

  // Memory window 0x100..0x1FF, word index = address bits 7:3.
  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= bytes_to_word(i);
    end else if (mem_we) begin
      mem[mem_addr[7:3]] <= mem_wdata;
    end
  end
  always @(negedge clk) if (mem_we) we_count <= we_count + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
    int size, a;
    logic [63:0] v;
    size = 1 << f3[1:0];
    a = int'(addr - 64'h100);
    v = 64'd0;
    for (int i = 0; i < size; i++) v = v | (64'(ref_bytes[a + i]) << (8 * i));
    if (!f3[2] && size < 8 && v[8*size-1])
      v = v | ~((64'd1 << (8 * size)) - 64'd1);
    return v;
  endfunction

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold, output logic [63:0] got);
    logic        exp_err;
    logic [63:0] exp_rdata;
    int          size, exp_lat, lat, we0, idx, a;
    size      = 1 << f3[1:0];
    exp_err   = (f3 == 3'd7) || (st && f3 >= 3'd4) || ((addr % size) != 0);
    exp_rdata = (exp_err || st) ? 64'd0 : ref_load(f3, addr);
    exp_lat   = exp_err ? 1 : ((!st || f3 == 3'd3) ? 2 : 3);
    idx       = int'(addr[7:3]);
    check_val("req_ready_idle", req_ready, 1);
    we0 = we_count;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = {$urandom, $urandom};
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    check_val("latency", 64'(lat), 64'(exp_lat));
    got = resp_rdata;
    check_val("rdata", resp_rdata, exp_rdata);
    check_val("err", resp_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_D; req_addr = 64'h100;
      @(negedge clk);
      check_val("hold_valid", resp_valid, 1);
      check_val("hold_rdata", resp_rdata, exp_rdata);
      check_val("hold_err", resp_err, exp_err);
      check_val("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_val("resp_drop", resp_valid, 0);
    check_val("we_count", 64'(we_count - we0), (st && !exp_err) ? 64'd1 : 64'd0);
    if (st && !exp_err) begin
      a = int'(addr - 64'h100);
      for (int i = 0; i < size; i++) ref_bytes[a + i] = wdata[8*i +: 8];
    end
    check_val("mem_word", mem[idx], bytes_to_word(idx));
    $display("txn st=%0d f3=%0d addr=0x%03h wdata=0x%016h -> rdata=0x%016h err=%0d lat=%0d",
             st, f3, addr[11:0], wdata, got, exp_err, lat);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] pre = 64'h8877_6655_4433_2211;
    logic [63:0] rw;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);
    for (int b = 0; b < 8; b++) ref_bytes[b] = pre[8*b +: 8];
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_resp_rdata", resp_rdata, 0);
    check_val("rst_resp_err", resp_err, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, F3_B,  64'h107, 64'd0, 0, got);
    check_val("t1_lb", got, 64'hFFFF_FFFF_FFFF_FF88);
    do_req(1'b0, F3_BU, 64'h107, 64'd0, 0, got);
    check_val("t2_lbu", got, 64'h88);
    do_req(1'b0, F3_WU, 64'h104, 64'd0, 0, got);
    check_val("t2_lwu", got, 64'h8877_6655);
    do_req(1'b0, F3_H,  64'h106, 64'd0, 0, got);
    check_val("t2_lh", got, 64'hFFFF_FFFF_FFFF_8877);
    do_req(1'b1, F3_H,  64'h102, 64'hABCD, 0, got);
    check_val("t3_sh_word", mem[0], 64'h8877_6655_ABCD_2211);
    do_req(1'b0, F3_W,  64'h102, 64'd0, 0, got);
    do_req(1'b1, F3_D,  64'h104, 64'h1234, 0, got);
    check_val("t4_mem_same", mem[0], 64'h8877_6655_ABCD_2211);
    do_req(1'b0, F3_D,  64'h100, 64'd0, 3, got);
    check_val("t5_ld", got, 64'h8877_6655_ABCD_2211);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f3;
      logic [63:0] ad;
      f3 = 3'($urandom_range(0, 7));
      ad = 64'h100 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((64'd1 << f3[1:0]) - 64'd1);
      do_req(1'($urandom), f3, ad, {$urandom, $urandom}, int'($urandom_range(0, 3)), got);
    end

    // Reset while in WRITE of an SB: the write must not land.
    rw = mem[1];
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 64'h10A; req_wdata = ~rw;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("t6_we_in_write", mem_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t6_resp_valid", resp_valid, 0);
    check_val("t6_resp_rdata", resp_rdata, 0);
    check_val("t6_resp_err", resp_err, 0);
    check_val("t6_mem_we", mem_we, 0);
    check_val("t6_mem_addr", mem_addr, 0);
    check_val("t6_mem_wdata", mem_wdata, 0);
    check_val("t6_req_ready", req_ready, 1);
    check_val("t6_mem_kept", mem[1], bytes_to_word(1));
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, F3_D, 64'h108, 64'd0, 0, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
